// File: rtl/garage_occupancy_display_pkg.sv
// Shared types and helpers for the garage occupancy display: direction FSM states
// and the active-low 7-segment encoding.
package garage_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENT1,
        ENT2,
        ENT3,
        EXT1,
        EXT2,
        EXT3,
        WAIT0
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Bit order {g,f,e,d,c,b,a}; anything outside 0..9 shows blank.
    function automatic logic [6:0] digit_to_seg(input logic [6:0] d);
        logic [6:0] seg;
        case (d)
            7'd0:    seg = 7'h40;
            7'd1:    seg = 7'h79;
            7'd2:    seg = 7'h24;
            7'd3:    seg = 7'h30;
            7'd4:    seg = 7'h19;
            7'd5:    seg = 7'h12;
            7'd6:    seg = 7'h02;
            7'd7:    seg = 7'h78;
            7'd8:    seg = 7'h00;
            7'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/garage_occupancy_display_if.sv
// Sensor inputs and display/status outputs of the occupancy display.
// master = the display block, slave = whatever drives the sensors and reads the display.
interface garage_occupancy_display_if;
    logic       sensor_a;
    logic       sensor_b;
    logic [6:0] seg_ones;
    logic [6:0] seg_tens;
    logic       digit_sel;
    logic [1:0] an;
    logic [6:0] count;
    logic       full;
    logic       empty;

    modport master (
        input  sensor_a, sensor_b,
        output seg_ones, seg_tens, digit_sel, an, count, full, empty
    );

    modport slave (
        output sensor_a, sensor_b,
        input  seg_ones, seg_tens, digit_sel, an, count, full, empty
    );
endinterface

// File: rtl/garage_occupancy_display_sensor_debounce.sv
// Two-flop synchronizer followed by a level debouncer: the output follows the
// synchronized input only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    output logic level_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level_o = level_q;
endmodule

// File: rtl/garage_occupancy_display.sv
// Occupancy counter driven by two debounced beam sensors, with registered
// 7-segment digit codes and a free-running digit refresh divider.
module garage_occupancy_display
    import garage_pkg::*;
#(
    parameter int CAPACITY        = 20,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int REFRESH_DIV     = 200000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    garage_occupancy_display_if.master    bus
);
    localparam logic [6:0] CAP_C = 7'(CAPACITY);
    localparam int         RW    = $clog2(REFRESH_DIV + 1);

    logic          a_deb, b_deb;
    state_e        state_q;
    logic          inc_q, dec_q;
    logic [6:0]    count_q, count_d;
    logic          full_q, empty_q;
    logic [6:0]    seg_ones_q, seg_tens_q;
    logic [RW-1:0] ref_q;
    logic          sel_q;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk(clk), .reset_n(reset_n), .raw_i(bus.sensor_a), .level_o(a_deb)
    );
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk(clk), .reset_n(reset_n), .raw_i(bus.sensor_b), .level_o(b_deb)
    );

    // Each state holds on its own sensor level; any other unlisted pair falls to WAIT0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
        end else begin
            inc_q <= 1'b0;
            dec_q <= 1'b0;
            case (state_q)
                IDLE: case ({a_deb, b_deb})
                    2'b10:   state_q <= ENT1;
                    2'b01:   state_q <= EXT1;
                    2'b11:   state_q <= WAIT0;
                    default: state_q <= IDLE;
                endcase
                ENT1: case ({a_deb, b_deb})
                    2'b11:   state_q <= ENT2;
                    2'b00:   state_q <= IDLE;
                    2'b10:   state_q <= ENT1;
                    default: state_q <= WAIT0;
                endcase
                ENT2: case ({a_deb, b_deb})
                    2'b01:   state_q <= ENT3;
                    2'b10:   state_q <= ENT1;
                    2'b11:   state_q <= ENT2;
                    default: state_q <= WAIT0;
                endcase
                ENT3: case ({a_deb, b_deb})
                    2'b00: begin
                        state_q <= IDLE;
                        inc_q   <= 1'b1;
                    end
                    2'b11:   state_q <= ENT2;
                    2'b01:   state_q <= ENT3;
                    default: state_q <= WAIT0;
                endcase
                EXT1: case ({a_deb, b_deb})
                    2'b11:   state_q <= EXT2;
                    2'b00:   state_q <= IDLE;
                    2'b01:   state_q <= EXT1;
                    default: state_q <= WAIT0;
                endcase
                EXT2: case ({a_deb, b_deb})
                    2'b10:   state_q <= EXT3;
                    2'b01:   state_q <= EXT1;
                    2'b11:   state_q <= EXT2;
                    default: state_q <= WAIT0;
                endcase
                EXT3: case ({a_deb, b_deb})
                    2'b00: begin
                        state_q <= IDLE;
                        dec_q   <= 1'b1;
                    end
                    2'b11:   state_q <= EXT2;
                    2'b10:   state_q <= EXT3;
                    default: state_q <= WAIT0;
                endcase
                default: state_q <= ({a_deb, b_deb} == 2'b00) ? IDLE : WAIT0;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (inc_q && count_q != CAP_C) begin
            count_d = count_q + 7'd1;
        end else if (dec_q && count_q != 7'd0) begin
            count_d = count_q - 7'd1;
        end
    end

    // Segment codes lag count by one cycle since they are derived from count_q.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q    <= 7'd0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            seg_ones_q <= digit_to_seg(7'd0);
            seg_tens_q <= SEG_BLANK;
        end else begin
            count_q    <= count_d;
            full_q     <= (count_d == CAP_C);
            empty_q    <= (count_d == 7'd0);
            seg_ones_q <= digit_to_seg(count_q % 7'd10);
            seg_tens_q <= (count_q < 7'd10) ? SEG_BLANK : digit_to_seg(count_q / 7'd10);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ref_q <= '0;
            sel_q <= 1'b0;
        end else if (ref_q == RW'(REFRESH_DIV - 1)) begin
            ref_q <= '0;
            sel_q <= ~sel_q;
        end else begin
            ref_q <= ref_q + RW'(1);
        end
    end

    assign bus.seg_ones  = seg_ones_q;
    assign bus.seg_tens  = seg_tens_q;
    assign bus.digit_sel = sel_q;
    assign bus.an        = sel_q ? 2'b01 : 2'b10;
    assign bus.count     = count_q;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
endmodule

// File: doc/garage_occupancy_display.md
# garage_occupancy_display

Tracks how many cars are inside the garage from two beam-break sensors and produces the two 7-segment digit codes shown on the display. Lies directly upstream of the 7-bit two-input display mux: `seg_ones` drives mux input i0, `seg_tens` drives i1, and `digit_sel` drives the mux select. It also drives the active-low digit anodes in step with `digit_sel`, and flags full and empty.

## Interface
- CAPACITY, 20: maximum car count, legal range 1..99.
- DEBOUNCE_CYCLES, 100000: number of cycles a synchronized sensor level must stay stable before it is accepted (1 ms at 100 MHz).
- REFRESH_DIV, 200000: number of cycles each digit is displayed before `digit_sel` toggles.
- clk  in  1  system clock; one clock domain.
- reset_n  in  1  synchronous, active-low reset.
- sensor_a  in  1  outer beam, 1 = blocked; asynchronous input.
- sensor_b  in  1  inner beam, 1 = blocked; asynchronous input.
- seg_ones  out  7  units digit; bit order {g,f,e,d,c,b,a}; active-low.
- seg_tens  out  7  tens digit, same encoding; blank (7'h7F) when count < 10.
- digit_sel  out  1  display mux select: 0 = ones, 1 = tens.
- an  out  2  active-low anodes; 2'b10 when digit_sel = 0, 2'b01 when digit_sel = 1.
- count  out  7  current occupancy, 0..CAPACITY.
- full  out  1  count == CAPACITY.
- empty  out  1  count == 0.

## Operation
- Each sensor passes through a 2-flop synchronizer, then the debouncer. The debounced level changes only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
- The direction FSM runs on the debounced pair {a,b}:
  - IDLE: 10 → ENT1; 01 → EXT1; 11 → WAIT0.
  - ENT1: 11 → ENT2; 00 → IDLE.
  - ENT2: 01 → ENT3; 10 → ENT1.
  - ENT3: 00 → IDLE and fire inc; 11 → ENT2.
  - EXT1: 11 → EXT2; 00 → IDLE.
  - EXT2: 10 → EXT3; 01 → EXT1.
  - EXT3: 00 → IDLE and fire dec; 11 → EXT2.
  - WAIT0: 00 → IDLE.
  - Any input not listed for the current state moves the FSM to WAIT0. No count change happens on a WAIT0 path.
- inc saturates at CAPACITY, and dec saturates at 0. A saturated event changes nothing else.
- Digits: tens = count / 10, ones = count % 10. Digits are converted to segment codes using the standard active-low table: 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30, 4 = 7'h19, 5 = 7'h12, 6 = 7'h02, 7 = 7'h78, 8 = 7'h00, 9 = 7'h10.
- Refresh: a free-running counter counts 0..REFRESH_DIV-1. When it wraps, `digit_sel` toggles and `an` follows it in the same cycle.

## Timing
- Reset (reset_n = 0 at a clk edge) sets:
  - FSM to IDLE and all counters to 0.
  - count = 0, full = 0, empty = 1.
  - seg_ones = 7'h40, seg_tens = 7'h7F.
  - digit_sel = 0, an = 2'b10.
  - Debounced levels to 0.
- Reset asserted mid-sequence discards the partial passage; no count change results.
- Latency from a raw sensor edge to the debounced change: 2 synchronizer cycles + DEBOUNCE_CYCLES.
- The FSM transition occurs one cycle after the debounced change.
- count, full and empty update on the clk edge after inc/dec fires.
- seg_ones and seg_tens are registered and update one cycle after count.
- A glitch shorter than DEBOUNCE_CYCLES never reaches the FSM.
- Both sensors changing in the same debounced cycle is handled by the FSM table above. Any pairing not listed there goes to WAIT0.
- The refresh counter runs independently of count updates and is never reset by them.

## Structure
- Package `garage_pkg` holds:
  - the FSM state enum (IDLE, ENT1..3, EXT1..3, WAIT0);
  - constant SEG_BLANK = 7'h7F;
  - the digit-to-segment function.
- Sub-module `sensor_debounce` contains the synchronizer and the debouncer, parameterised by DEBOUNCE_CYCLES. It is instantiated twice, once per sensor.
- Top level: FSM, saturating counter, binary-to-BCD divide by 10, segment registers, refresh divider.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4, REFRESH_DIV = 8, CAPACITY = 12, with each sensor phase held 10 cycles.
- Reset: drive reset_n low for 2 cycles. Required: count = 0, empty = 1, seg_ones = 7'h40, seg_tens = 7'h7F, an = 2'b10.
- Entry: apply a→ab→b→none once. Required: count = 1, seg_ones = 7'h79, tens blank, empty = 0. Repeat 11 more times. Required: count = 12, full = 1, seg_tens = 7'h79, seg_ones = 7'h24.
- Saturation: from count 12, one more entry leaves count at 12. From count 0, an exit sequence (b→ab→a→none) leaves count at 0.
- Aborts and illegal input:
  - a→none: count unchanged.
  - a→ab→a→none: count unchanged.
  - Jump none→ab: FSM goes to WAIT0 and the count is unchanged.
- Glitch and reset:
  - A 3-cycle sensor_a pulse causes no FSM transition.
  - reset_n asserted during ENT2 results in IDLE with count = 0.
- Refresh: digit_sel toggles every 8 cycles. `an` alternates 2'b10 / 2'b01 in the same cycle as each toggle.
